// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the 32-bit word width, the default NOP and reset PC values, the
// fetch FSM state encodings, the hold-buffer record and a word-align helper.
package instruction_fetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INST_DEF = 32'h0000_0000;
  localparam word_t RESET_PC_DEF = 32'h0000_0000;

  // Fetch FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // One fetched word together with the address it came from
  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_word_t;

  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/ack bus.
//   imem_req     : request strobe, held with imem_addr until imem_ack
//   imem_addr    : word-aligned fetch address
//   imem_ack     : completion strobe; imem_rd_data valid in the same cycle
//   imem_rd_data : fetched instruction word
// master = fetch unit, slave = instruction memory.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rd_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rd_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rd_data
  );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register.
//   clk, reset        : clock, asynchronous active-high reset
//   load              : capture inst_in/pc_in, mark valid
//   flush             : replace contents with a bubble (NOP, invalid); wins over load
//   inst_in, pc_in    : word and its address from the fetch stage
//   inst_out, pc_out, pc_plus4_out, inst_valid : registered outputs to decode
// Neither load nor flush: contents hold (decode stalled).
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter word_t NOP_INST = NOP_INST_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  word_t inst_in,
  input  word_t pc_in,
  output word_t inst_out,
  output word_t pc_out,
  output word_t pc_plus4_out,
  output logic  inst_valid
);

  // IF -> ID boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_out     <= NOP_INST;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      inst_valid   <= 1'b0;
    end else if (flush) begin
      // pc_out/pc_plus4_out keep their last value; only the word is bubbled
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_out     <= inst_in;
      pc_out       <= pc_in;
      pc_plus4_out <= pc_in + 32'd4;
      inst_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
//   clk, reset           : clock, asynchronous active-high reset
//   stall_flag_id_in     : decode cannot accept; IF/ID holds
//   redirect_valid/_pc   : taken branch/jump target from downstream
//   imem (master)        : instruction-memory request/ack bus
//   inst_out, pc_out, pc_plus4_out, inst_valid : IF/ID register outputs
//   stall_flag_if_out    : fetch is waiting on memory with nothing ready
// FSM: IDLE (one cycle after reset) -> REQ (request at pc) -> HOLD (acked
// word parked while decode stalls) / DRAIN (discard the response to a
// request overtaken by a redirect).
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter word_t NOP_INST = NOP_INST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_flag_id_in,
  input  logic                redirect_valid,
  input  word_t               redirect_pc,
  instruction_fetch_if.master imem,
  output word_t               inst_out,
  output word_t               pc_out,
  output word_t               pc_plus4_out,
  output logic                inst_valid,
  output logic                stall_flag_if_out
);

  logic [1:0]  state;
  word_t       pc;
  word_t       drain_addr;
  fetch_word_t hold_p0;
  logic        vld_p0;

  logic  acked;
  logic  ifid_load;
  logic  ifid_flush;
  word_t ifid_inst;
  word_t ifid_pc;

  // A usable response only exists in REQ; acks in IDLE (stale after reset)
  // and in DRAIN (stale after redirect) are ignored.
  assign acked = (state == ST_REQ) && imem.imem_ack;

  // In DRAIN the abandoned request must stay stable on the bus until its ack,
  // even though pc already points at the redirect target.
  assign imem.imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
  assign imem.imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

  assign stall_flag_if_out = (state == ST_IDLE) || (state == ST_DRAIN) ||
                             ((state == ST_REQ) && !imem.imem_ack);

  // IF/ID steering: fresh ack goes straight through, otherwise the parked
  // word is released. With decode free and nothing to give, a bubble is
  // inserted so decode never sees the same word twice.
  always_comb begin
    ifid_load = 1'b0;
    ifid_inst = imem.imem_rd_data;
    ifid_pc   = pc;
    if (!redirect_valid && !stall_flag_id_in) begin
      if (acked) begin
        ifid_load = 1'b1;
      end else if ((state == ST_HOLD) && vld_p0) begin
        ifid_load = 1'b1;
        ifid_inst = hold_p0.inst;
        ifid_pc   = hold_p0.pc;
      end
    end
  end

  assign ifid_flush = redirect_valid || (!stall_flag_id_in && !ifid_load);

  // Fetch control; redirect outranks stall and ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      vld_p0 <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= align_word(redirect_pc);
      vld_p0 <= 1'b0;
      if (((state == ST_REQ) || (state == ST_DRAIN)) && !imem.imem_ack) begin
        state <= ST_DRAIN;
      end else begin
        state <= ST_REQ;
      end
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imem.imem_ack) begin
            if (stall_flag_id_in) begin
              // pc advances only when the parked word is released
              vld_p0 <= 1'b1;
              state  <= ST_HOLD;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_flag_id_in) begin
            pc     <= pc + 32'd4;
            vld_p0 <= 1'b0;
            state  <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem.imem_ack) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Hold-buffer and drain-address payloads; emptiness is tracked by vld_p0/state
  always_ff @(posedge clk) begin
    if (!redirect_valid && acked && stall_flag_id_in) begin
      hold_p0.inst <= imem.imem_rd_data;
      hold_p0.pc   <= pc;
    end
    if (redirect_valid && (state == ST_REQ) && !imem.imem_ack) begin
      drain_addr <= pc;
    end
  end

  if_id_register #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .load         (ifid_load),
    .flush        (ifid_flush),
    .inst_in      (ifid_inst),
    .pc_in        (ifid_pc),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .inst_valid   (inst_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: random stall/redirect/memory-latency stimulus,
// an architectural PC-stream model feeding a scoreboard queue, and a monitor
// that checks every instruction decode accepts plus bus/IF-ID properties.
module tb_instruction_fetch;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0040;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;
  localparam int          GAP_LIMIT  = 100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_flag_id_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        inst_valid;
  logic        stall_flag_if_out;

  instruction_fetch_if imem ();

  instruction_fetch #(
    .RESET_PC (T_RESET_PC),
    .NOP_INST (T_NOP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_flag_id_in  (stall_flag_id_in),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem              (imem),
    .inst_out          (inst_out),
    .pc_out            (pc_out),
    .pc_plus4_out      (pc_plus4_out),
    .inst_valid        (inst_valid),
    .stall_flag_if_out (stall_flag_if_out)
  );

  initial forever #5 clk = ~clk;

  // Memory content: every word reads as its own address plus one
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'd1;
  endfunction

  // Shared state: driver owns the model, monitor owns the counters
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          lat_max = 0;
  logic        zero_wait_phase = 1'b1;
  int          checks = 0;
  int          errors = 0;

  // ---------------- driver / reference model ----------------
  int stall_run = 0;

  task automatic top_up();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc   = model_pc;
      e.inst = mem_word(model_pc);
      e.pc4  = model_pc + 32'd4;
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic restart_model();
    exp_q.delete();
    model_pc = T_RESET_PC;
    top_up();
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      stall_flag_id_in = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = $urandom;
      top_up();
    end
  endtask

  task automatic drive_random();
    @(negedge clk);
    if (stall_run > 0) stall_run = stall_run - 1;
    else if ($urandom_range(0, 4) == 0) stall_run = $urandom_range(1, 4);
    stall_flag_id_in = (stall_run > 0);
    redirect_valid   = ($urandom_range(0, 19) == 0);
    case ($urandom_range(0, 3))
      0:       redirect_pc = 32'hFFFF_FFFC;
      1:       redirect_pc = 32'h0000_0103;
      default: redirect_pc = $urandom;
    endcase
    if (redirect_valid) begin
      // everything not yet accepted by decode is wrong-path
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end
    top_up();
  endtask

  initial begin
    reset            = 1'b1;
    stall_flag_id_in = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    model_pc         = T_RESET_PC;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    restart_model();
    quiet(12);
    @(negedge clk);
    zero_wait_phase = 1'b0;
    lat_max         = 3;
    top_up();
    repeat (1500) drive_random();

    // async reset while a slow request is outstanding
    stall_run = 0;
    lat_max   = 6;
    quiet(3);
    @(negedge clk);
    stall_flag_id_in = 1'b0;
    redirect_valid   = 1'b0;
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    lat_max = 3;
    restart_model();
    quiet(3);
    repeat (1500) drive_random();
    quiet(6);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- memory responder ----------------
  logic r_pend    = 1'b0;
  logic prev_rst  = 1'b1;
  int   wcnt      = 0;
  int   cur_lat   = 0;

  always @(negedge clk) begin
    if (reset) begin
      imem.imem_ack     = 1'b0;
      imem.imem_rd_data = 32'h0;
      r_pend            = 1'b0;
    end else if (prev_rst && !imem.imem_req) begin
      // stray ack in the first cycle after reset must be ignored
      imem.imem_ack     = 1'b1;
      imem.imem_rd_data = 32'hDEAD_BEEF;
    end else if (imem.imem_req) begin
      if (!r_pend) begin
        r_pend  = 1'b1;
        wcnt    = 0;
        cur_lat = $urandom_range(0, lat_max);
      end
      if (wcnt >= cur_lat) begin
        imem.imem_ack     = 1'b1;
        imem.imem_rd_data = mem_word(imem.imem_addr);
        r_pend            = 1'b0;
      end else begin
        imem.imem_ack     = 1'b0;
        imem.imem_rd_data = $urandom;
        wcnt              = wcnt + 1;
      end
    end else begin
      imem.imem_ack     = 1'b0;
      imem.imem_rd_data = $urandom;
      r_pend            = 1'b0;
    end
    prev_rst = reset;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  logic        prev_ok = 1'b0;
  logic        prev_stall, prev_redirect, prev_valid;
  logic [31:0] prev_inst, prev_pc, prev_pc4;
  logic        out_pend = 1'b0;
  logic [31:0] pend_addr;
  int          cyc = 0;
  int          since_deliv = 0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      check32("rst_inst_out", inst_out, T_NOP);
      check1 ("rst_inst_valid", inst_valid, 1'b0);
      check32("rst_pc_out", pc_out, 32'h0);
      check32("rst_pc_plus4", pc_plus4_out, 32'h0);
      check1 ("rst_imem_req", imem.imem_req, 1'b0);
      check32("rst_imem_addr", imem.imem_addr, T_RESET_PC);
      check1 ("rst_stall_if", stall_flag_if_out, 1'b1);
      prev_ok     = 1'b0;
      out_pend    = 1'b0;
      cyc         = 0;
      since_deliv = 0;
    end else begin
      if (out_pend) begin
        check1 ("req_stable", imem.imem_req, 1'b1);
        check32("addr_stable", imem.imem_addr, pend_addr);
      end
      out_pend  = imem.imem_req && !imem.imem_ack;
      pend_addr = imem.imem_addr;
      if (imem.imem_req) check32("addr_align", {30'h0, imem.imem_addr[1:0]}, 32'h0);
      if (imem.imem_req && !imem.imem_ack) check1("stall_if_waiting", stall_flag_if_out, 1'b1);

      if (cyc == 0) begin
        check1("idle_stall_if", stall_flag_if_out, 1'b1);
        check1("idle_no_req", imem.imem_req, 1'b0);
      end
      if (cyc == 1) begin
        check1 ("first_req", imem.imem_req, 1'b1);
        check32("first_addr", imem.imem_addr, T_RESET_PC);
        if (zero_wait_phase) check1("zero_wait_stall_if", stall_flag_if_out, 1'b0);
      end
      if (zero_wait_phase && cyc >= 2) check1("zero_wait_valid", inst_valid, 1'b1);

      if (prev_ok && prev_redirect) begin
        check1("redirect_flush", inst_valid, 1'b0);
      end else if (prev_ok && prev_stall) begin
        check32("stall_hold_inst", inst_out, prev_inst);
        check32("stall_hold_pc", pc_out, prev_pc);
        check32("stall_hold_pc4", pc_plus4_out, prev_pc4);
        check1 ("stall_hold_valid", inst_valid, prev_valid);
      end
      if (!inst_valid) check32("bubble_nop", inst_out, T_NOP);

      if (inst_valid && !stall_flag_id_in && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_inst: got pc %h inst %h expected none", pc_out, inst_out);
        end else begin
          e = exp_q.pop_front();
          check32("deliv_pc", pc_out, e.pc);
          check32("deliv_inst", inst_out, e.inst);
          check32("deliv_pc4", pc_plus4_out, e.pc4);
        end
        since_deliv = 0;
      end else begin
        since_deliv = since_deliv + 1;
      end
      check1("progress", (since_deliv <= GAP_LIMIT), 1'b1);

      prev_ok       = 1'b1;
      prev_stall    = stall_flag_id_in;
      prev_redirect = redirect_valid;
      prev_valid    = inst_valid;
      prev_inst     = inst_out;
      prev_pc       = pc_out;
      prev_pc4      = pc_plus4_out;
      cyc           = cyc + 1;
    end
  end

endmodule
